// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared encodings for the data-port arbiter.
//   gnt_e   : grant indicator driven on GNT (none / M0 / M1)
//   state_e : arbiter FSM states
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_M0   = 2'b01,
    GNT_M1   = 2'b10
  } gnt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN0  = 2'b01,
    ST_OWN1  = 2'b10,
    ST_LOCK1 = 2'b11
  } state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter for the single data port of the shared
// instruction/data memory. M0 (CPU MEM stage) has priority; M1 (loader/debug)
// is guaranteed a grant after MAXHOLD consecutive M0 grants and may lock the
// port for bursts. One access per cycle; read data returns one cycle later.
//
// Ports:
//   CLK, RESET_N                 clock, async active-low reset
//   REQ0/WE0/ADDR0/DIN0          M0 request (held until ACK0)
//   ACK0, STALL0                 M0 accepted / pipeline stall
//   RVALID0, DOUT0               M0 read data return
//   REQ1/WE1/ADDR1/DIN1, LOCK1   M1 request, LOCK1 keeps ownership
//   ACK1, RVALID1, DOUT1         M1 accept / read data return
//   MADDR, MDIN, MWE             memory port (combinational from grant)
//   MDOUT                        memory read data (registered in memory)
//   GNT                          00 none, 01 M0, 10 M1
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DBITS   = 16,
  parameter int ABITS   = 12,
  parameter int MAXHOLD = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             REQ0,
  input  logic             WE0,
  input  logic [ABITS-1:0] ADDR0,
  input  logic [DBITS-1:0] DIN0,
  output logic             ACK0,
  output logic             STALL0,
  output logic             RVALID0,
  output logic [DBITS-1:0] DOUT0,
  input  logic             REQ1,
  input  logic             WE1,
  input  logic [ABITS-1:0] ADDR1,
  input  logic [DBITS-1:0] DIN1,
  input  logic             LOCK1,
  output logic             ACK1,
  output logic             RVALID1,
  output logic [DBITS-1:0] DOUT1,
  output logic [ABITS-1:0] MADDR,
  output logic [DBITS-1:0] MDIN,
  output logic             MWE,
  input  logic [DBITS-1:0] MDOUT,
  output logic [1:0]       GNT
);

  localparam logic [7:0] MAXHOLD_C = 8'(MAXHOLD);

  state_e     r_state;
  logic [7:0] r_streak;
  logic       r_rvalid0;
  logic       r_rvalid1;

  state_e     w_state_nxt;
  logic [7:0] w_streak_nxt;
  gnt_e       w_gnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_IDLE;
      r_streak  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_streak  <= w_streak_nxt;
      r_rvalid0 <= (w_gnt == GNT_M0) && !WE0;
      r_rvalid1 <= (w_gnt == GNT_M1) && !WE1;
    end
  end

  always_comb begin
    w_gnt        = GNT_NONE;
    w_state_nxt  = ST_IDLE;
    w_streak_nxt = r_streak;

    if (r_state == ST_LOCK1) begin
      // M1 dropping its request releases the lock in the same cycle,
      // so a waiting M0 is served immediately.
      if (REQ1)      w_gnt = GNT_M1;
      else if (REQ0) w_gnt = GNT_M0;
    end else if (REQ0 && REQ1) begin
      w_gnt = (r_streak == MAXHOLD_C) ? GNT_M1 : GNT_M0;
    end else if (REQ0) begin
      w_gnt = GNT_M0;
    end else if (REQ1) begin
      w_gnt = GNT_M1;
    end

    unique case (w_gnt)
      GNT_M1:  w_state_nxt = LOCK1 ? ST_LOCK1 : ST_OWN1;
      GNT_M0:  w_state_nxt = ST_OWN0;
      default: w_state_nxt = ST_IDLE;
    endcase

    if (!REQ1 || (w_gnt == GNT_M1))
      w_streak_nxt = '0;
    else if ((w_gnt == GNT_M0) && (r_streak != MAXHOLD_C))
      w_streak_nxt = r_streak + 8'd1;
  end

  always_comb begin
    MADDR = '0;
    MDIN  = '0;
    MWE   = 1'b0;
    unique case (w_gnt)
      GNT_M0: begin
        MADDR = ADDR0;
        MDIN  = DIN0;
        MWE   = WE0;
      end
      GNT_M1: begin
        MADDR = ADDR1;
        MDIN  = DIN1;
        MWE   = WE1;
      end
      default: ;
    endcase
  end

  assign ACK0    = (w_gnt == GNT_M0);
  assign ACK1    = (w_gnt == GNT_M1);
  assign STALL0  = REQ0 && !ACK0;
  assign GNT     = w_gnt;
  assign RVALID0 = r_rvalid0;
  assign RVALID1 = r_rvalid1;
  assign DOUT0   = MDOUT;
  assign DOUT1   = MDOUT;

endmodule
